// File: rtl/rgb_to_gray_framer.sv
// rgb_to_gray_framer: forwards a 4-byte width/height header, then turns RGB byte triples into gray bytes.
module rgb_to_gray_framer #(
  parameter int DATA_BITS = 8,
  parameter int MAX_WIDTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic                 frame_done
);
  typedef enum logic [1:0] {HEADER, PIXEL, DONE} state_t;
  localparam int SW = DATA_BITS + 8;
  state_t                 state;
  logic [1:0]             hdr_idx, chan;
  logic [2*DATA_BITS-1:0] width;
  logic [DATA_BITS-1:0]   height_lo, r, g;
  logic [31:0]            pixel_count, pixel_total, total;
  logic [SW-1:0]          sum;
  logic                   out_last, in_xfer, out_xfer;
  assign ready_in   = (state != DONE) && (!valid_out || ready_out);
  assign in_xfer    = valid_in && ready_in;
  assign out_xfer   = valid_out && ready_out;
  assign frame_done = out_xfer && out_last;
  assign total      = 32'(width) * 32'({data_in, height_lo});
  assign sum        = SW'(77) * SW'(r) + SW'(150) * SW'(g) + SW'(29) * SW'(data_in);
  // out_last travels with the byte in the output register so frame_done lines up with its transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HEADER;
      hdr_idx     <= '0;
      chan        <= '0;
      width       <= '0;
      height_lo   <= '0;
      r           <= '0;
      g           <= '0;
      pixel_count <= '0;
      pixel_total <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      if (out_xfer) valid_out <= 1'b0;
      case (state)
        HEADER: if (in_xfer) begin
          data_out  <= data_in;
          valid_out <= 1'b1;
          hdr_idx   <= hdr_idx + 2'd1;
          out_last  <= (hdr_idx == 2'd3) && (total == 32'd0);
          if (hdr_idx == 2'd0) width[DATA_BITS-1:0] <= data_in;
          if (hdr_idx == 2'd1) width[2*DATA_BITS-1:DATA_BITS] <= data_in;
          if (hdr_idx == 2'd2) height_lo <= data_in;
          if (hdr_idx == 2'd3) begin
            pixel_total <= total;
            pixel_count <= '0;
            chan        <= '0;
            state       <= (total == 32'd0) ? HEADER : PIXEL;
          end
        end
        PIXEL: if (in_xfer) begin
          chan <= (chan == 2'd2) ? 2'd0 : chan + 2'd1;
          if (chan == 2'd0) r <= data_in;
          if (chan == 2'd1) g <= data_in;
          if (chan == 2'd2) begin
            data_out    <= sum[SW-1:8];
            valid_out   <= 1'b1;
            pixel_count <= pixel_count + 32'd1;
            out_last    <= (pixel_count + 32'd1 == pixel_total);
            if (pixel_count + 32'd1 == pixel_total) state <= DONE;
          end
        end
        default: if (out_xfer) state <= HEADER;
      endcase
    end
  end
endmodule
